// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg : shared constants and address decode for the four-bank memory
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam int NUM_BANKS = 4;
  localparam int WORD_W    = 16;
  localparam int ROW_W     = 13;
  localparam int RD_LAT    = 2;
  localparam int BANK_BUSY = 4;

  // Byte address layout: row in [15:3], bank in [2:1], lsb must be zero.
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [1:0]       bank;
    logic             lsb;
  } addr_t;

  function automatic addr_t decode_addr(input logic [15:0] addr);
    return addr_t'(addr);
  endfunction

  function automatic logic [1:0] bank_sel(input addr_t a);
    return a.bank;
  endfunction

  function automatic logic [ROW_W-1:0] row_sel(input addr_t a);
    return a.row;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bank.sv
// ---------------------------------------------------------------------------
// mem_bank : one storage bank with its occupancy down-counter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_bank #(
  parameter int ROW_W     = 13,
  parameter int BANK_BUSY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [ROW_W-1:0]  row,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              busy
);

  localparam logic [1:0] C_BUSY_LOAD = 2'(BANK_BUSY - 1);

  logic [15:0] mem_q [2**ROW_W];
  logic [15:0] rdata_q;
  logic [1:0]  cnt_q, cnt_d;

  // Accept only happens with the counter at zero, so load and decrement never collide.
  always_comb begin
    cnt_d = cnt_q;
    if (sel) begin
      cnt_d = C_BUSY_LOAD;
    end else if (cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Storage and its read register are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (sel && we) begin
      mem_q[row] <= wdata;
    end
    if (sel && !we) begin
      rdata_q <= mem_q[row];
    end
  end

  assign rdata = rdata_q;
  assign busy  = (cnt_q != 2'd0);

endmodule

`default_nettype wire

// File: rtl/four_bank_mem.sv
// ---------------------------------------------------------------------------
// four_bank_mem : four-bank interleaved memory with 2-cycle read return
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module four_bank_mem #(
  parameter int ROW_W     = 13,
  parameter int RD_LAT    = 2,
  parameter int BANK_BUSY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] DataOut,
  output logic        data_vld,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  import mem_pkg::*;

  if (RD_LAT != 2) begin : g_rd_lat_check
    $error("four_bank_mem supports RD_LAT = 2 only");
  end

  addr_t       w_addr;
  logic [1:0]  w_bank;
  logic        w_req;
  logic        w_accept;
  logic [3:0]  w_busy;
  logic [15:0] w_rdata [NUM_BANKS];

  logic        rvld_q, rvld_d;
  logic [1:0]  rbank_q, rbank_d;
  logic        data_vld_q, data_vld_d;
  logic [15:0] data_out_q, data_out_d;

  assign w_addr   = decode_addr(Addr);
  assign w_bank   = bank_sel(w_addr);
  assign w_req    = rd ^ wr;
  assign err      = (rd & wr) | ((rd | wr) & w_addr.lsb);
  assign w_accept = w_req & ~err & ~w_busy[w_bank];
  assign stall    = w_req & ~err &  w_busy[w_bank];
  assign busy     = w_busy;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    mem_bank #(
      .ROW_W     (ROW_W),
      .BANK_BUSY (BANK_BUSY)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .sel   (w_accept && (w_bank == 2'(i))),
      .we    (wr),
      .row   (row_sel(w_addr)),
      .wdata (DataIn),
      .rdata (w_rdata[i]),
      .busy  (w_busy[i])
    );
  end

  // Stage 1 lives in the bank's read register; only its valid and bank index travel here.
  always_comb begin
    rvld_d     = w_accept & rd;
    rbank_d    = (w_accept & rd) ? w_bank : rbank_q;
    data_vld_d = rvld_q;
    data_out_d = rvld_q ? w_rdata[rbank_q] : data_out_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvld_q     <= 1'b0;
      rbank_q    <= 2'd0;
      data_vld_q <= 1'b0;
      data_out_q <= 16'h0000;
    end else begin
      rvld_q     <= rvld_d;
      rbank_q    <= rbank_d;
      data_vld_q <= data_vld_d;
      data_out_q <= data_out_d;
    end
  end

  assign DataOut  = data_out_q;
  assign data_vld = data_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_four_bank_mem.sv
// ---------------------------------------------------------------------------
// tb_four_bank_mem : scenario and randomized checks against a behavioural model
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_four_bank_mem;

  localparam int BB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn;
  logic        rd, wr;
  logic [15:0] DataOut;
  logic        data_vld, stall, err;
  logic [3:0]  busy;

  always #5 clk = ~clk;

  four_bank_mem dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .rd(rd), .wr(wr),
    .DataOut(DataOut), .data_vld(data_vld), .stall(stall), .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: word-addressed store, per-bank "free from cycle", list of pending returns.
  typedef struct { int due; logic [15:0] data; } pend_t;
  logic [15:0] mem_m [int];
  int          free_at [4];
  pend_t       pend [$];
  logic [15:0] m_dout;
  logic        m_vld, m_err, m_stall, m_acc;
  logic [3:0]  m_busy;

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < 4; i++) free_at[i] = 0;
    m_dout = 16'h0000;
    m_vld  = 1'b0;
  endtask

  task automatic model_eval();
    int  b;
    logic req;
    b     = int'(Addr[2:1]);
    req   = rd ^ wr;
    m_err = (rd & wr) | ((rd | wr) & Addr[0]);
    for (int i = 0; i < 4; i++) m_busy[i] = (cyc < free_at[i]);
    m_stall = req & ~m_err &  m_busy[b];
    m_acc   = req & ~m_err & ~m_busy[b];
    m_vld   = 1'b0;
    foreach (pend[j]) if (pend[j].due == cyc) begin m_vld = 1'b1; m_dout = pend[j].data; end
  endtask

  task automatic apply(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; Addr = a; DataIn = d;
    #2;
    model_eval();
  endtask

  task automatic tick();
    if (m_acc) begin
      free_at[Addr[2:1]] = cyc + BB;
      if (wr) mem_m[int'(Addr[15:1])] = DataIn;
      else    pend.push_back(pend_t'{cyc + 2, mem_m[int'(Addr[15:1])]});
    end
    @(posedge clk); #1;
    cyc++;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin apply(0, 0, 16'h0, 16'h0); tick(); end
  endtask

  task automatic drive_held(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    for (int t = 0; t < 8; t++) begin
      apply(r, w, a, d);
      if (!m_stall) begin tick(); return; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    apply(0, 0, 16'h0, 16'h0);
    model_reset();
    model_eval();
    checks++;
    if ({DataOut, data_vld, busy, stall, err} !== {16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset got dout=%h vld=%b busy=%b stall=%b err=%b want 0000 0 0000 0 0",
               DataOut, data_vld, busy, stall, err);
    end
    @(posedge clk); #1;
    cyc++;
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    logic [15:0] seq_a [5] = '{16'h0010, 16'h0, 16'h0, 16'h0, 16'h0010};
    logic        seq_r [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        seq_w [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      if (k < 5) apply(seq_r[k], seq_w[k], seq_a[k], 16'hBEEF);
      else       apply(0, 0, 16'h0, 16'h0);
      checks++;
      if ({DataOut, data_vld, busy, stall, err} !== {m_dout, m_vld, m_busy, m_stall, m_err}) begin
        errors++;
        $display("FAIL write_read k=%0d got dout=%h vld=%b busy=%b stall=%b err=%b want %h %b %b %b %b",
                 k, DataOut, data_vld, busy, stall, err, m_dout, m_vld, m_busy, m_stall, m_err);
      end
      if (k == 6) begin
        checks++;
        if (DataOut !== 16'hBEEF || data_vld !== 1'b1) begin
          errors++;
          $display("FAIL write_read_data got dout=%h vld=%b want BEEF 1", DataOut, data_vld);
        end
      end
      tick();
    end
  endtask

  task automatic test_streaming();
    logic [15:0] exp_d [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) drive_held(0, 1, 16'h0100 + 16'(2*i), exp_d[i]);
    idle(4);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) apply(1, 0, 16'h0100 + 16'(2*k), 16'h0);
      else       apply(0, 0, 16'h0, 16'h0);
      checks++;
      if ({DataOut, data_vld, busy, stall, err} !== {m_dout, m_vld, m_busy, m_stall, m_err} || stall !== 1'b0) begin
        errors++;
        $display("FAIL stream k=%0d got dout=%h vld=%b busy=%b stall=%b err=%b want %h %b %b 0 %b",
                 k, DataOut, data_vld, busy, stall, err, m_dout, m_vld, m_busy, m_err);
      end
      if (k >= 2 && k < 6) begin
        checks++;
        if (DataOut !== exp_d[k-2] || data_vld !== 1'b1) begin
          errors++;
          $display("FAIL stream_data k=%0d got dout=%h vld=%b want %h 1", k, DataOut, data_vld, exp_d[k-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    int acc_at;
    drive_held(0, 1, 16'h0000, 16'hA5A5);
    drive_held(0, 1, 16'h0008, 16'h5A5A);
    idle(4);
    apply(1, 0, 16'h0000, 16'h0);
    tick();
    acc_at = -1;
    for (int k = 1; k <= 8 && acc_at < 0; k++) begin
      apply(1, 0, 16'h0008, 16'h0);
      checks++;
      if ({DataOut, data_vld, busy, stall, err} !== {m_dout, m_vld, m_busy, m_stall, m_err}) begin
        errors++;
        $display("FAIL conflict k=%0d got dout=%h vld=%b busy=%b stall=%b err=%b want %h %b %b %b %b",
                 k, DataOut, data_vld, busy, stall, err, m_dout, m_vld, m_busy, m_stall, m_err);
      end
      if (stall === 1'b0) acc_at = k;
      tick();
    end
    checks++;
    if (acc_at != 4) begin
      errors++;
      $display("FAIL conflict_accept got accept at N+%0d want N+4", acc_at);
    end
    for (int k = 0; k < 2; k++) begin
      apply(0, 0, 16'h0, 16'h0);
      if (k == 1) begin
        checks++;
        if (DataOut !== 16'h5A5A || data_vld !== 1'b1) begin
          errors++;
          $display("FAIL conflict_data got dout=%h vld=%b want 5A5A 1", DataOut, data_vld);
        end
      end
      tick();
    end
  endtask

  task automatic test_errors();
    idle(4);
    for (int k = 0; k < 5; k++) begin
      case (k)
        0:       apply(1, 1, 16'h0020, 16'h7777);
        1:       apply(1, 0, 16'h0003, 16'h0);
        2:       apply(0, 1, 16'h0011, 16'h1);
        default: apply(0, 0, 16'h0, 16'h0);
      endcase
      checks++;
      if ({DataOut, data_vld, busy, stall, err} !== {m_dout, m_vld, m_busy, m_stall, m_err} ||
          (k < 3 && {err, stall, busy, data_vld} !== {1'b1, 1'b0, 4'b0000, 1'b0})) begin
        errors++;
        $display("FAIL errors k=%0d got dout=%h vld=%b busy=%b stall=%b err=%b want %h %b %b %b %b",
                 k, DataOut, data_vld, busy, stall, err, m_dout, m_vld, m_busy, m_stall, m_err);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive_held(0, 1, 16'h0040, 16'h1234);
    idle(4);
    apply(1, 0, 16'h0040, 16'h0);
    tick();
    apply(0, 0, 16'h0, 16'h0);
    rst = 1'b0;
    model_reset();
    model_eval();
    #1;
    checks++;
    if (busy !== 4'b0000 || data_vld !== 1'b0 || DataOut !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid got busy=%b vld=%b dout=%h want 0000 0 0000", busy, data_vld, DataOut);
    end
    rst = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) apply(1, 0, 16'h0040, 16'h0);
      else        apply(0, 0, 16'h0, 16'h0);
      checks++;
      if ({DataOut, data_vld, busy, stall, err} !== {m_dout, m_vld, m_busy, m_stall, m_err} ||
          (k == 0 && data_vld !== 1'b0) || (k == 3 && {DataOut, data_vld} !== {16'h1234, 1'b1})) begin
        errors++;
        $display("FAIL reset_after k=%0d got dout=%h vld=%b busy=%b stall=%b err=%b want %h %b %b %b %b",
                 k, DataOut, data_vld, busy, stall, err, m_dout, m_vld, m_busy, m_stall, m_err);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [12:0] row;
    logic [15:0] a;
    int          op;
    for (int k = 0; k < 400; k++) begin
      case ($urandom % 4)
        0:       row = 13'h0000;
        1:       row = 13'h0001;
        2:       row = 13'h1FFF;
        default: row = 13'($urandom);
      endcase
      a  = {row, 2'($urandom), 1'b0};
      op = int'($urandom % 8);
      if (op <= 2 && !mem_m.exists(int'(a[15:1]))) op = 3;
      case (op)
        0, 1, 2: apply(1, 0, a, 16'h0);
        3, 4:    apply(0, 1, a, 16'($urandom));
        5:       apply(0, 0, a, 16'h0);
        6:       apply(1, 1, a, 16'($urandom));
        default: apply($urandom % 2 == 0, 1'b0, a | 16'h0001, 16'h0);
      endcase
      checks++;
      if ({DataOut, data_vld, busy, stall, err} !== {m_dout, m_vld, m_busy, m_stall, m_err}) begin
        errors++;
        $display("FAIL random k=%0d addr=%h got dout=%h vld=%b busy=%b stall=%b err=%b want %h %b %b %b %b",
                 k, Addr, DataOut, data_vld, busy, stall, err, m_dout, m_vld, m_busy, m_stall, m_err);
      end
      tick();
    end
  endtask

  initial begin
    rd = 1'b0; wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
    model_reset();
    test_reset();
    test_write_read();
    test_streaming();
    test_conflict();
    test_errors();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/four_bank_mem.md
# four_bank_mem

Four-bank interleaved main-memory model that sits directly downstream of the cache controller and services its line fill and writeback traffic. It takes the controller's memory-side request (`Addr`, `DataIn`, `rd`, `wr`) and returns read data a fixed 2 cycles after acceptance. Per-bank occupancy lets the controller stream four consecutive half-aligned words of a line on back-to-back cycles. A bank conflict stalls the requester; a malformed request raises `err`.

## Interface
- `ROW_W`, default 13: row-address bits per bank (`Addr[15:3]`).
- `RD_LAT`, default 2: cycles from request acceptance to `DataOut` valid. Fixed at 2; other values are unsupported.
- `BANK_BUSY`, default 4: cycles a bank is occupied per access, including the accept cycle.
- `clk` in 1: single clock; all state is on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `Addr` in 16: byte address.
  - Bank select is `Addr[2:1]`.
  - Row is `Addr[15:3]`.
  - `Addr[0]` must be 0.
- `DataIn` in 16: write data.
- `rd` in 1: read request, level, held until accepted.
- `wr` in 1: write request, level, held until accepted.
- `DataOut` out 16: read data, registered.
- `data_vld` out 1: `DataOut` carries the result of an accepted read this cycle.
- `stall` out 1: the present request is not accepted this cycle (target bank busy). Combinational.
- `busy` out 4: per-bank occupancy, bit i means bank i.
- `err` out 1: malformed request this cycle. Combinational.

## Operation
- **Request definition.** `req = rd ^ wr`.
- **Error cases.** `err = (rd & wr) | ((rd | wr) & Addr[0])`.
  - An erroring request is never accepted.
  - It causes no state change and leaves `stall` low.
- **Acceptance.** `accept = req & ~err & ~busy[Addr[2:1]]`.
  - `stall = req & ~err & busy[Addr[2:1]]`.
- **Write.** Updates `bank[Addr[2:1]][Addr[15:3]]` at the accept edge.
- **Read.** Samples the array at the accept edge, i.e. it sees all writes accepted in earlier cycles. The sampled word enters a 2-stage `{vld, data}` pipeline.
- **Bank busy counter.** Each bank has a 2-bit down-counter.
  - On accept the counter loads `BANK_BUSY-1`.
  - `busy[i] = (cnt_i != 0)`.
  - The counter decrements every cycle while non-zero.
  - A bank can therefore accept again `BANK_BUSY` cycles after its previous accept.
- **Independence.** Different banks are independent, so one accept per cycle gives full 4-bank pipelining.
- **Arithmetic.** Counters saturate at 0, with no wrap. Rows wrap naturally within `ROW_W` bits; there is no bounds error.

## Timing
- **Reset values.**
  - `DataOut` = 16'h0000.
  - `data_vld` = 0.
  - `busy` = 4'b0000.
  - `stall` and `err` follow their combinational definitions.
  - Pipeline valids and bank counters clear asynchronously.
  - Array contents are not reset and are retained across reset.
- **Read latency.** A read accepted in cycle N gives `data_vld` = 1 and valid `DataOut` during cycle N+2, for exactly one cycle.
  - When `data_vld` = 0, `DataOut` holds its last value.
- **Write.** Takes effect at the end of the accept cycle. Nothing is returned.
- **Same-bank back-to-back.** Accept in cycle N gives `stall` = 1 for a same-bank request in cycles N+1..N+3; it is accepted in N+4.
- **Simultaneous events.** Only one request port exists, so there are no arbitration cases. A counter reload and its decrement never coincide, because accept requires the counter to be 0.
- **Reset mid-operation.**
  - In-flight reads are discarded; no `data_vld` follows.
  - Every bank becomes free immediately.
  - A write accepted before the reset edge remains in the array.

## Structure
- **Package `mem_pkg`.**
  - Constants: `NUM_BANKS = 4`, `WORD_W = 16`, `ROW_W`, `RD_LAT`, `BANK_BUSY`.
  - Bank-select and row-extract helpers.
- **Sub-module `mem_bank`, instantiated 4×.**
  - Holds the storage array and the busy counter.
  - Inputs: `clk`, `rst`, `sel`, `we`, `row`, `wdata`.
  - Outputs: `rdata` (sampled at the edge) and `busy`.
- **Top level.** Decode, error/stall logic, read-data mux and the 2-stage return pipeline.

## Test plan
- **Write then read.**
  - Stimulus: `wr`, `Addr` = 16'h0010, `DataIn` = 16'hBEEF; later `rd` of 16'h0010 once bank 0 is free.
  - Required response: `DataOut` = 16'hBEEF with `data_vld` exactly 2 cycles after the read accept.
- **Line streaming.**
  - Stimulus: preload 16'h1111/2222/3333/4444 at 16'h0100/0102/0104/0106, then issue `rd` on four consecutive cycles N..N+3.
  - Required response: `stall` never asserted; data in order during cycles N+2..N+5.
- **Bank conflict.**
  - Stimulus: `rd` 16'h0000 at cycle N, then `rd` 16'h0008 held from N+1.
  - Required response: `stall` = 1 during N+1..N+3, accept at N+4, `data_vld` at N+6.
- **Errors.**
  - Stimulus: `rd` = `wr` = 1 at 16'h0020, then `rd` at 16'h0003.
  - Required response: `err` = 1 and `stall` = 0 in both cycles; `busy` stays 4'b0000; no `data_vld`.
- **Reset mid-read.**
  - Stimulus: write 16'h1234 at 16'h0040, accept a read of it at cycle N, pulse `rst` low during N+1.
  - Required response: no `data_vld` at N+2; `busy` = 0 during reset. After release, a read of 16'h0040 returns 16'h1234.
